// File: rtl/scaled_sprite_renderer.sv
// scaled_sprite_renderer: indexed image stretched to the active area, frame-synced fade.
// Optional SCALED_SPRITE_TRANSPARENT_EN masks texels whose index equals TRANSP_IDX.
module scaled_sprite_renderer #(
  parameter int SRC_W      = 300,
  parameter int SRC_H      = 300,
  parameter int SCR_W      = 640,
  parameter int SCR_H      = 480,
  parameter int ADDR_W     = 17,
  parameter int IDX_W      = 4,
  parameter int FADE_STEP  = 1,
  parameter int TRANSP_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              fade_in,
  input  logic              fade_out,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque,
  output logic              fade_busy,
  output logic [4:0]        level
);

  localparam int XA_W = $clog2(SRC_W + SCR_W) + 1;
  localparam int YA_W = $clog2(SRC_H + SCR_H) + 1;
  localparam int SX_W = $clog2(SRC_W) + 1;
  localparam int XK   = 1 + (SRC_W - 1) / SCR_W;
  localparam int YK   = 1 + (SRC_H - 1) / SCR_H;

  localparam logic [9:0]        SCR_W_D = 10'(SCR_W);
  localparam logic [9:0]        SCR_H_D = 10'(SCR_H);
  localparam logic [XA_W-1:0]   SRC_W_X = XA_W'(SRC_W);
  localparam logic [XA_W-1:0]   SCR_W_X = XA_W'(SCR_W);
  localparam logic [YA_W-1:0]   SRC_H_Y = YA_W'(SRC_H);
  localparam logic [YA_W-1:0]   SCR_H_Y = YA_W'(SCR_H);
  localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
  localparam logic [4:0]        STEP_L  = 5'(FADE_STEP);

  if (SRC_W * SRC_H > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("ADDR_W too small for SRC_W*SRC_H");
  end
  if (FADE_STEP < 1 || FADE_STEP > 16) begin : g_bad_step
    $error("FADE_STEP must be 1..16");
  end
  if (TRANSP_IDX < 0 || TRANSP_IDX >= (1 << IDX_W)) begin : g_bad_transp
    $error("TRANSP_IDX out of palette range");
  end

  typedef enum logic [1:0] {
    HIDDEN,
    FADE_IN,
    SHOWN,
    FADE_OUT
  } fade_t;

  logic [SX_W-1:0]   src_x, src_x_n;
  logic [XA_W-1:0]   x_acc, x_acc_n;
  logic [YA_W-1:0]   y_acc, y_acc_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic [9:0]        y_last;
  logic [1:0]        blank_d;
  logic              active;
  logic              show;
  logic              frame_start;
  logic [5:0]        lvl_up;
  fade_t             state;

  // Several subtractions per pixel cover SRC_W > SCR_W.
  always_comb begin
    src_x_n = src_x;
    x_acc_n = x_acc;
    if (DrawX == '0) begin
      src_x_n = '0;
      x_acc_n = '0;
    end else if (DrawX < SCR_W_D) begin
      x_acc_n = x_acc + SRC_W_X;
      for (int i = 0; i < XK; i++) begin
        if (x_acc_n >= SCR_W_X) begin
          x_acc_n = x_acc_n - SCR_W_X;
          src_x_n = src_x_n + SX_W'(1);
        end
      end
    end
  end

  always_comb begin
    y_acc_n    = y_acc;
    row_base_n = row_base;
    if (DrawX == '0) begin
      if (DrawY == '0) begin
        y_acc_n    = '0;
        row_base_n = '0;
      end else if (DrawY != y_last && DrawY < SCR_H_D) begin
        y_acc_n = y_acc + SRC_H_Y;
        for (int i = 0; i < YK; i++) begin
          if (y_acc_n >= SCR_H_Y) begin
            y_acc_n    = y_acc_n - SCR_H_Y;
            row_base_n = row_base_n + SRC_W_A;
          end
        end
      end
    end
  end

  assign active      = (DrawX < SCR_W_D) && (DrawY < SCR_H_D);
  assign frame_start = (DrawX == '0) && (DrawY == '0);
  assign lvl_up      = {1'b0, level} + {1'b0, STEP_L};
  assign pal_index   = rom_q;

`ifdef SCALED_SPRITE_TRANSPARENT_EN
  assign show = blank_d[1] && (rom_q != IDX_W'(TRANSP_IDX));
`else
  assign show = blank_d[1];
`endif

  function automatic logic [3:0] fade_chan(input logic [3:0] c,
                                           input logic [4:0] l);
    logic [8:0] p;
    p = {5'b0, c} * {4'b0, l};
    return 4'(p >> 4);
  endfunction

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      src_x       <= '0;
      x_acc       <= '0;
      y_acc       <= '0;
      row_base    <= '0;
      y_last      <= '0;
      rom_address <= '0;
      blank_d     <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      opaque      <= 1'b0;
    end else begin
      src_x       <= src_x_n;
      x_acc       <= x_acc_n;
      y_acc       <= y_acc_n;
      row_base    <= row_base_n;
      y_last      <= DrawY;
      rom_address <= active ? row_base_n + ADDR_W'(src_x_n) : '0;
      blank_d     <= {blank_d[0], blank};
      red         <= show ? fade_chan(pal_red, level) : '0;
      green       <= show ? fade_chan(pal_green, level) : '0;
      blue        <= show ? fade_chan(pal_blue, level) : '0;
      opaque      <= show;
    end
  end

  // Requests redirect immediately; level only moves at frame start.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state     <= HIDDEN;
      level     <= '0;
      fade_busy <= 1'b0;
    end else if (fade_out && (state == SHOWN || state == FADE_IN)) begin
      state     <= FADE_OUT;
      fade_busy <= 1'b1;
    end else if (fade_in && (state == HIDDEN || state == FADE_OUT)) begin
      state     <= FADE_IN;
      fade_busy <= 1'b1;
    end else if (frame_start) begin
      unique case (1'b1)
        (state == FADE_IN): begin
          if (lvl_up >= 6'd16) begin
            level     <= 5'd16;
            state     <= SHOWN;
            fade_busy <= 1'b0;
          end else begin
            level <= lvl_up[4:0];
          end
        end
        (state == FADE_OUT): begin
          if (level <= STEP_L) begin
            level     <= '0;
            state     <= HIDDEN;
            fade_busy <= 1'b0;
          end else begin
            level <= level - STEP_L;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scaled_sprite_renderer.sv
// tb_scaled_sprite_renderer: directed vectors for addressing, fade FSM and colour path.
// Transparency expectations follow SCALED_SPRITE_TRANSPARENT_EN when it is defined.
module tb_scaled_sprite_renderer;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, fade_in, fade_out;
  logic [16:0] rom_address;
  logic [3:0]  rom_q, pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        opaque, fade_busy;
  logic [4:0]  level;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x;
    int y;
    int exp;
  } addr_vec_t;

  addr_vec_t vecs[11];

  scaled_sprite_renderer dut (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .fade_in    (fade_in),
    .fade_out   (fade_out),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .pal_index  (pal_index),
    .pal_red    (pal_red),
    .pal_green  (pal_green),
    .pal_blue   (pal_blue),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .opaque     (opaque),
    .fade_busy  (fade_busy),
    .level      (level)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic frame();
    DrawX = 10'd0;
    DrawY = 10'd0;
    tick();
    DrawX = 10'd700;
    tick();
  endtask

  task automatic run_to(input int x, input int y);
    DrawX = 10'd0;
    DrawY = 10'd0;
    tick();
    for (int r = 1; r <= y; r++) begin
      DrawY = 10'(r);
      DrawX = 10'd0;
      tick();
    end
    for (int c = 1; c <= x; c++) begin
      DrawX = 10'(c);
      tick();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_op, exp_r;
    vecs[0]  = '{1, 0, 0};
    vecs[1]  = '{3, 0, 1};
    vecs[2]  = '{320, 0, 150};
    vecs[3]  = '{639, 0, 299};
    vecs[4]  = '{700, 0, 0};
    vecs[5]  = '{5, 1, 2};
    vecs[6]  = '{0, 2, 300};
    vecs[7]  = '{2, 2, 300};
    vecs[8]  = '{100, 240, 45046};
    vecs[9]  = '{639, 479, 89999};
    vecs[10] = '{10, 480, 0};

    Reset = 1'b1;
    DrawX = '0;
    DrawY = '0;
    blank = 1'b0;
    fade_in = 1'b0;
    fade_out = 1'b0;
    rom_q = 4'd5;
    pal_red = 4'd15;
    pal_green = 4'd10;
    pal_blue = 4'd3;
    #1;
    check("reset rom_address", int'(rom_address), 0);
    check("reset level", int'(level), 0);
    check("reset fade_busy", int'(fade_busy), 0);
    check("reset red", int'(red), 0);
    tick();
    tick();
    Reset = 1'b0;

    foreach (vecs[i]) begin
      run_to(vecs[i].x, vecs[i].y);
      check($sformatf("addr x=%0d y=%0d", vecs[i].x, vecs[i].y),
            int'(rom_address), vecs[i].exp);
    end

    // fade in from HIDDEN
    blank = 1'b1;
    DrawX = 10'd700;
    DrawY = 10'd0;
    tick();
    fade_in = 1'b1;
    tick();
    fade_in = 1'b0;
    check("fade_in busy", int'(fade_busy), 1);
    check("fade_in level held", int'(level), 0);
    for (int f = 1; f <= 16; f++) begin
      frame();
      check($sformatf("fade_in level f=%0d", f), int'(level), f);
      check($sformatf("fade_in busy f=%0d", f), int'(fade_busy),
            (f < 16) ? 1 : 0);
      if (f == 8) begin
        tick(); tick(); tick();
        check("red lvl8", int'(red), 7);
        check("green lvl8", int'(green), 5);
        check("blue lvl8", int'(blue), 1);
        check("opaque lvl8", int'(opaque), 1);
        check("pal_index", int'(pal_index), 5);
        blank = 1'b0;
        tick(); tick();
        check("red blank 2cyc", int'(red), 7);
        tick();
        check("red blank 3cyc", int'(red), 0);
        check("opaque blank 3cyc", int'(opaque), 0);
        blank = 1'b1;
        tick(); tick(); tick();
      end
    end
    tick();
    check("red lvl16", int'(red), 15);

    // transparent index
`ifdef SCALED_SPRITE_TRANSPARENT_EN
    exp_op = 0;
    exp_r  = 0;
`else
    exp_op = 1;
    exp_r  = 15;
`endif
    rom_q = 4'd0;
    tick(); tick(); tick();
    check("opaque idx0", int'(opaque), exp_op);
    check("red idx0", int'(red), exp_r);
    rom_q = 4'd5;
    tick(); tick(); tick();
    check("opaque idx5", int'(opaque), 1);
    check("red idx5", int'(red), 15);

    // fade out to 10, then reverse
    fade_out = 1'b1;
    tick();
    fade_out = 1'b0;
    check("fade_out busy", int'(fade_busy), 1);
    for (int k = 0; k < 6; k++) frame();
    check("fade_out level10", int'(level), 10);
    fade_in = 1'b1;
    tick();
    fade_in = 1'b0;
    check("reverse level held", int'(level), 10);
    check("reverse busy", int'(fade_busy), 1);
    frame();
    check("reverse level11", int'(level), 11);
    for (int k = 0; k < 5; k++) frame();
    check("back to 16", int'(level), 16);
    check("shown busy", int'(fade_busy), 0);

    // simultaneous requests: fade_out wins
    fade_in = 1'b1;
    fade_out = 1'b1;
    tick();
    fade_in = 1'b0;
    fade_out = 1'b0;
    check("both busy", int'(fade_busy), 1);
    frame();
    check("both level15", int'(level), 15);

    // async reset mid-line, mid-fade
    DrawX = 10'd300;
    DrawY = 10'd5;
    tick(); tick(); tick();
    check("red lvl15", int'(red), 14);
    check("green lvl15", int'(green), 9);
    #2;
    Reset = 1'b1;
    #1;
    check("mid reset red", int'(red), 0);
    check("mid reset green", int'(green), 0);
    check("mid reset blue", int'(blue), 0);
    check("mid reset opaque", int'(opaque), 0);
    check("mid reset rom_address", int'(rom_address), 0);
    check("mid reset level", int'(level), 0);
    check("mid reset busy", int'(fade_busy), 0);
    tick();
    Reset = 1'b0;
    frame();
    check("hidden after reset", int'(level), 0);
    fade_out = 1'b1;
    tick();
    fade_out = 1'b0;
    check("fade_out ignored hidden", int'(fade_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scaled_sprite_renderer.md
# scaled_sprite_renderer

Parametrised successor to the fixed 300x300 start-screen image block. It renders an indexed-colour image of any source size, stretched to the active VGA area, and adds a frame-synchronous fade-in/fade-out controller. Source coordinates come from incremental accumulators, so no per-pixel multiplier or divider is needed. The block sits between the VGA controller (DrawX/DrawY/blank) and the colour mux. It drives an external synchronous image ROM and uses an external combinational palette.

## Interface
Parameters:
- SRC_W, 300, source image width in texels
- SRC_H, 300, source image height in texels
- SCR_W, 640, active screen width in pixels
- SCR_H, 480, active screen height in pixels
- ADDR_W, 17, ROM address width; must satisfy SRC_W*SRC_H <= 2^ADDR_W
- IDX_W, 4, palette index width
- FADE_STEP, 1, level increment/decrement per frame (1..16)
- TRANSP_IDX, 0, transparent palette index (used only with SCALED_SPRITE_TRANSPARENT_EN)

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- DrawX  in  10  current pixel column; increments by 1 per vga_clk within a line
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video
- fade_in  in  1  single-cycle request to start fading in
- fade_out  in  1  single-cycle request to start fading out
- rom_address  out  ADDR_W  registered address to the synchronous ROM
- rom_q  in  IDX_W  ROM data; valid 1 cycle after the address
- pal_index  out  IDX_W  equals rom_q, driven to the palette
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index
- red, green, blue  out  4 each  registered, faded colour
- opaque  out  1  registered; 1 = the pixel should overwrite the background
- fade_busy  out  1  1 while FADE_IN or FADE_OUT
- level  out  5  current brightness, 0..16

## Operation
- Horizontal stepping:
  - At DrawX==0: src_x=0 and x_acc=0.
  - For 0<DrawX<SCR_W: x_acc += SRC_W; while x_acc >= SCR_W, subtract SCR_W and increment src_x.
  - Result: src_x = floor(DrawX*SRC_W/SCR_W).
- Vertical stepping:
  - At DrawY==0, DrawX==0: src_y=0, y_acc=0, row_base=0.
  - When DrawY changes with 0<DrawY<SCR_H, y stepping is done once, at DrawX==0; row_base += SRC_W on each src_y increment.
- Address output:
  - rom_address = row_base + src_x, registered.
  - Outside the active area (DrawX>=SCR_W or DrawY>=SCR_H), rom_address holds 0.
- Accumulator widths are sized to hold SRC + SCR without overflow. If SRC exceeds SCR, one cycle may advance by more than one texel; the result must still match the floor formula.
- Fade FSM (advances at frame start, DrawX==0 && DrawY==0):
  - HIDDEN (level 0). fade_in moves to FADE_IN.
  - FADE_IN: level += FADE_STEP per frame, saturating at 16, then SHOWN.
  - SHOWN (level 16). fade_out moves to FADE_OUT.
  - FADE_OUT: level -= FADE_STEP per frame, floored at 0, then HIDDEN.
  - fade_in during FADE_OUT reverses to FADE_IN from the current level; fade_out during FADE_IN reverses likewise.
  - If fade_in and fade_out are asserted in the same cycle, fade_out wins.
  - Requests are latched immediately; the state changes at the request edge, and the level changes only at frame start.
- Colour: each channel = (pal_c * level) >> 4, so level 16 is exact and level 0 is black. The output is forced to 0 when delayed blank==0.

## Timing
- Pipeline:
  - Cycle 0: DrawX/DrawY/blank sampled.
  - Cycle 1: rom_address registered.
  - Cycle 2: rom_q valid; palette result (combinational).
  - Cycle 3: red/green/blue/opaque registered.
- Total latency is 3 vga_clk. blank is delayed 3 cycles to stay aligned.
- Reset (asynchronous, immediate): all outputs 0, rom_address 0, accumulators 0, FSM HIDDEN, level 0, fade_busy 0.
- Reset mid-fade abandons the fade; the block restarts in HIDDEN.
- DrawX wrap from 799 to 0 reinitialises the horizontal stepping with no carry-over.

## Configuration
- SCALED_SPRITE_TRANSPARENT_EN defined: opaque = 0 and RGB = 0 when the delayed index == TRANSP_IDX or delayed blank==0; otherwise opaque = 1.
- SCALED_SPRITE_TRANSPARENT_EN undefined: no index compare logic; opaque = delayed blank.

## Test plan
- Defaults, Reset pulse mid-line -> all outputs 0 at once, level 0, FSM HIDDEN.
- Line 0 sweep -> rom_address for DrawX=1,3,639 is 0,1,299 (each appearing 1 cycle later); DrawX=700 -> 0.
- DrawY=479, DrawX=639 -> rom_address 89999; DrawY=1 row -> row_base 0; DrawY=2 -> row_base 300.
- fade_in pulse, FADE_STEP=1 -> level 1..16 over 16 frame starts, fade_busy 1 then 0; pal_red=15 at level 8 -> red=7.
- fade_in at level 10 during FADE_OUT -> the next frame gives level 11; simultaneous fade_in+fade_out in SHOWN -> FADE_OUT.
- With the macro and TRANSP_IDX=0: rom_q=0 -> opaque=0, RGB=0 three cycles later; rom_q=5 -> opaque=1.
